// File: rtl/shaper_pkg.sv
// shaper_pkg: config bundle, pipeline latency and output clamp
// helpers shared by the multi-channel recursive shaping filter.
package shaper_pkg;

  localparam int SHAPER_LAT = 4;
  localparam int CFG_KLW    = 8;
  localparam int CFG_MW     = 16;
  localparam int SAT_W      = 64;

  // Fields sized for the largest supported k/l/m widths;
  // narrower run-time values are zero-extended on load.
  typedef struct packed {
    logic [CFG_KLW-1:0] k;
    logic [CFG_KLW-1:0] l;
    logic [CFG_MW-1:0]  m1;
    logic [CFG_MW-1:0]  m2;
  } shaper_cfg_t;

  function automatic logic signed [SAT_W-1:0] sat_hi(
    input int w
  );
    logic [SAT_W-1:0] one;
    one = SAT_W'(1);
    return $signed((one << (w - 1)) - one);
  endfunction

  // Clamp v into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] shaper_sat(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = sat_hi(w);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic shaper_clip(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    hi = sat_hi(w);
    return (v > hi) || (v < ~hi);
  endfunction

endpackage

// File: rtl/shaper_filter_mc_delay.sv
// shaper_delay_line: per-channel sample history; registers taps
// x(n), x(n-k), x(n-l), x(n-l-1) with channel/valid (stage S1).
module shaper_delay_line
  import shaper_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int IN_W  = 12,
  parameter int K_MAX = 15,
  parameter int L_MAX = 15,
  parameter int CW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               valid,
  input  logic [CW-1:0]      chan,
  input  logic [IN_W-1:0]    data,
  input  logic [CFG_KLW-1:0] k,
  input  logic [CFG_KLW-1:0] l,
  output logic               tap_valid,
  output logic [CW-1:0]      tap_chan,
  output logic [IN_W-1:0]    x_n,
  output logic [IN_W-1:0]    x_nk,
  output logic [IN_W-1:0]    x_nl,
  output logic [IN_W-1:0]    x_nl1
);

  // hist[c][i] holds x(n-1-i) of channel c
  localparam int HD = (K_MAX > L_MAX + 1) ? K_MAX : L_MAX + 1;

  logic [IN_W-1:0] hist [NCH][HD];
  logic [IN_W-1:0] row  [HD];
  logic [IN_W-1:0] nk;
  logic [IN_W-1:0] nl;
  logic [IN_W-1:0] nl1;
  logic            accept;

  assign accept = valid && (int'(chan) < NCH);

  always_comb begin
    for (int i = 0; i < HD; i++) row[i] = '0;
    for (int c = 0; c < NCH; c++)
      if (int'(chan) == c) row = hist[c];
    // k=0 selects x(n) itself so dk becomes 0
    nk  = (k == '0) ? data : '0;
    nl  = (l == '0) ? data : '0;
    nl1 = '0;
    for (int i = 0; i < HD; i++) begin
      if (int'(k) == i + 1) nk = row[i];
      if (int'(l) == i + 1) nl = row[i];
      if (int'(l) == i) nl1 = row[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < HD; i++)
          hist[c][i] <= '0;
      tap_valid <= 1'b0;
      tap_chan  <= '0;
      x_n       <= '0;
      x_nk      <= '0;
      x_nl      <= '0;
      x_nl1     <= '0;
    end else if (clear) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < HD; i++)
          hist[c][i] <= '0;
      tap_valid <= 1'b0;
    end else begin
      tap_valid <= accept;
      if (accept) begin
        tap_chan <= chan;
        x_n      <= data;
        x_nk     <= nk;
        x_nl     <= nl;
        x_nl1    <= nl1;
        for (int c = 0; c < NCH; c++) begin
          if (int'(chan) == c) begin
            hist[c][0] <= data;
            for (int i = 1; i < HD; i++)
              hist[c][i] <= hist[c][i-1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/shaper_filter_mc.sv
// shaper_filter_mc: time-multiplexed recursive pulse shaper.
// Ports: clk/reset, cfg_* + cfg_load, in_* stream, out_* stream, ovf.
module shaper_filter_mc
  import shaper_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int IN_W      = 12,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 4,
  parameter int K_MAX     = 15,
  parameter int L_MAX     = 15,
  parameter int COEF_W    = 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int KW = (K_MAX > 0) ? $clog2(K_MAX + 1) : 1,
  localparam int LW = (L_MAX > 0) ? $clog2(L_MAX + 1) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [KW-1:0]     cfg_k,
  input  logic [LW-1:0]     cfg_l,
  input  logic [COEF_W-1:0] cfg_m1,
  input  logic [COEF_W-1:0] cfg_m2,
  input  logic              in_valid,
  input  logic [CW-1:0]     in_chan,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  output logic [CW-1:0]     out_chan,
  output logic [OUT_W-1:0]  out_data,
  output logic              ovf
);

  shaper_cfg_t cfg;
  logic [KW-1:0] k_cl;
  logic [LW-1:0] l_cl;

  assign k_cl = (int'(cfg_k) > K_MAX) ? KW'(K_MAX) : cfg_k;
  assign l_cl = (int'(cfg_l) > L_MAX) ? LW'(L_MAX) : cfg_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg <= '0;
    end else if (cfg_load) begin
      cfg.k  <= CFG_KLW'(k_cl);
      cfg.l  <= CFG_KLW'(l_cl);
      cfg.m1 <= CFG_MW'(cfg_m1);
      cfg.m2 <= CFG_MW'(cfg_m2);
    end
  end

  logic            t_valid;
  logic [CW-1:0]   t_chan;
  logic [IN_W-1:0] x_n;
  logic [IN_W-1:0] x_nk;
  logic [IN_W-1:0] x_nl;
  logic [IN_W-1:0] x_nl1;

  shaper_delay_line #(
    .NCH   (NCH),
    .IN_W  (IN_W),
    .K_MAX (K_MAX),
    .L_MAX (L_MAX),
    .CW    (CW)
  ) u_dly (
    .clk       (clk),
    .reset     (reset),
    .clear     (cfg_load),
    .valid     (in_valid),
    .chan      (in_chan),
    .data      (in_data),
    .k         (cfg.k),
    .l         (cfg.l),
    .tap_valid (t_valid),
    .tap_chan  (t_chan),
    .x_n       (x_n),
    .x_nk      (x_nk),
    .x_nl      (x_nl),
    .x_nl1     (x_nl1)
  );

  logic signed [ACC_W-1:0] p_arr [NCH];
  logic signed [ACC_W-1:0] q_arr [NCH];
  logic signed [ACC_W-1:0] s_arr [NCH];

  logic signed [ACC_W-1:0] k_ext, m1_ext, m2_ext;
  logic signed [ACC_W-1:0] dk, d1, p_old, p_new;
  logic signed [ACC_W-1:0] q_old, q_new, s_old, s_new;

  logic                    v2, v3;
  logic [CW-1:0]           ch2, ch3;
  logic signed [ACC_W-1:0] p2, s3;

  assign k_ext  = $signed(ACC_W'(cfg.k));
  assign m1_ext = $signed(ACC_W'(cfg.m1));
  assign m2_ext = $signed(ACC_W'(cfg.m2));

  assign dk = $signed(ACC_W'(x_n)) - $signed(ACC_W'(x_nk));
  assign d1 = $signed(ACC_W'(x_nl)) - $signed(ACC_W'(x_nl1));

  // Each array is read and written in one stage, so the same
  // channel on consecutive cycles sees its own update.
  always_comb begin
    p_old = '0;
    q_old = '0;
    s_old = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(t_chan) == c) p_old = p_arr[c];
      if (int'(ch2) == c) begin
        q_old = q_arr[c];
        s_old = s_arr[c];
      end
    end
  end

  assign p_new = p_old + dk - k_ext * d1;
  assign q_new = q_old + m2_ext * p2;
  assign s_new = s_old + q_new + m1_ext * p2;

  logic signed [ACC_W-1:0] sh;
  logic signed [SAT_W-1:0] sh_w;
  logic [OUT_W-1:0]        out_d;
  logic                    clip;

  assign sh    = s3 >>> OUT_SHIFT;
  assign sh_w  = {{(SAT_W-ACC_W){sh[ACC_W-1]}}, sh};
  assign out_d = OUT_W'(shaper_sat(sh_w, OUT_W));
  assign clip  = shaper_clip(sh_w, OUT_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        p_arr[c] <= '0;
        q_arr[c] <= '0;
        s_arr[c] <= '0;
      end
      v2        <= 1'b0;
      v3        <= 1'b0;
      ch2       <= '0;
      ch3       <= '0;
      p2        <= '0;
      s3        <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else if (cfg_load) begin
      for (int c = 0; c < NCH; c++) begin
        p_arr[c] <= '0;
        q_arr[c] <= '0;
        s_arr[c] <= '0;
      end
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      v2        <= t_valid;
      v3        <= v2;
      out_valid <= v3;
      if (t_valid) begin
        ch2 <= t_chan;
        p2  <= p_new;
        for (int c = 0; c < NCH; c++)
          if (int'(t_chan) == c) p_arr[c] <= p_new;
      end
      if (v2) begin
        ch3 <= ch2;
        s3  <= s_new;
        for (int c = 0; c < NCH; c++) begin
          if (int'(ch2) == c) begin
            q_arr[c] <= q_new;
            s_arr[c] <= s_new;
          end
        end
      end
      if (v3) begin
        out_chan <= ch3;
        out_data <= out_d;
        if (clip) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shaper_filter_mc.sv
// tb_shaper_filter_mc: directed checks of the shaping filter
// on three instances (1 ch, 4 ch, 4 ch with 8-bit output).
module tb_shaper_filter_mc;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        cfg_load = 1'b0;
  logic [3:0]  cfg_k    = '0;
  logic [3:0]  cfg_l    = '0;
  logic [7:0]  cfg_m1   = '0;
  logic [7:0]  cfg_m2   = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_chan  = '0;
  logic [11:0] in_data  = '0;

  logic              a_valid, a_chan, a_ovf;
  logic signed [15:0] a_data;
  logic              b_valid, b_ovf;
  logic [1:0]        b_chan;
  logic signed [15:0] b_data;
  logic              c_valid, c_ovf;
  logic [1:0]        c_chan;
  logic signed [7:0] c_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shaper_filter_mc #(.NCH(1), .OUT_W(16), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m1(cfg_m1), .cfg_m2(cfg_m2),
    .in_valid(in_valid), .in_chan(in_chan[0]), .in_data(in_data),
    .out_valid(a_valid), .out_chan(a_chan), .out_data(a_data),
    .ovf(a_ovf)
  );

  shaper_filter_mc #(.NCH(4), .OUT_W(16), .OUT_SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m1(cfg_m1), .cfg_m2(cfg_m2),
    .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
    .out_valid(b_valid), .out_chan(b_chan), .out_data(b_data),
    .ovf(b_ovf)
  );

  shaper_filter_mc #(.NCH(4), .OUT_W(8), .OUT_SHIFT(0)) dut_c (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m1(cfg_m1), .cfg_m2(cfg_m2),
    .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
    .out_valid(c_valid), .out_chan(c_chan), .out_data(c_data),
    .ovf(c_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch,
                       input int d);
    in_valid = v;
    in_chan  = ch;
    in_data  = 12'(d);
  endtask

  task automatic load(input int k, input int l, input int m1,
                      input int m2, input logic v);
    cfg_k    = 4'(k);
    cfg_l    = 4'(l);
    cfg_m1   = 8'(m1);
    cfg_m2   = 8'(m2);
    cfg_load = 1'b1;
    drive(v, 2'd0, 100);
    step();
    cfg_load = 1'b0;
    drive(1'b0, 2'd0, 0);
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if (a_valid !== 1'b0 || a_data !== 16'sd0 || a_chan !== 1'b0) begin
      bad++;
      $display("FAIL reset_a got v=%0b d=%0d c=%0b want 0/0/0",
               a_valid, a_data, a_chan);
    end
    total++;
    if (a_ovf !== 1'b0 || b_valid !== 1'b0 || c_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got aovf=%0b bv=%0b covf=%0b want 0",
               a_ovf, b_valid, c_ovf);
    end
    #4 reset = 1'b1;
    step();
  endtask

  // sparse impulse on ch0, with ch1 samples a 1-channel DUT drops
  task automatic test_impulse();
    int e[6] = '{100, 200, -100, 0, 0, 0};
    logic signed [15:0] w;
    int j;
    load(4, 2, 1, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i < 12)
        drive(1'b1, 2'(i % 2), (i == 0) ? 100 : ((i % 2) * 999));
      else
        drive(1'b0, 2'd0, 0);
      step();
      j = i - 3;
      total++;
      if (j >= 0 && j < 12 && (j % 2) == 0) begin
        w = 16'(e[j / 2]);
        if (a_valid !== 1'b1 || a_data !== w || a_chan !== 1'b0) begin
          bad++;
          $display("FAIL impulse[%0d] got v=%0b d=%0d want 1/%0d",
                   i, a_valid, a_data, w);
        end
      end else if (a_valid !== 1'b0) begin
        bad++;
        $display("FAIL impulse_idle[%0d] got v=%0b want 0", i, a_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int e[4] = '{100, 200, -100, 0};
    logic signed [15:0] w;
    int j, ch, r;
    load(4, 2, 1, 0, 1'b0);
    for (int i = 0; i < 27; i++) begin
      if (i < 24) drive(1'b1, 2'(i % 4), (i == 2) ? 100 : 0);
      else drive(1'b0, 2'd0, 0);
      step();
      j = i - 3;
      total++;
      if (j >= 0) begin
        ch = j % 4;
        r  = j / 4;
        w  = (ch == 2 && r < 4) ? 16'(e[r]) : 16'sd0;
        if (b_valid !== 1'b1 || b_chan !== 2'(ch) || b_data !== w) begin
          bad++;
          $display("FAIL rr[%0d] got v=%0b c=%0d d=%0d want 1/%0d/%0d",
                   i, b_valid, b_chan, b_data, ch, w);
        end
      end else if (b_valid !== 1'b0) begin
        bad++;
        $display("FAIL rr_idle[%0d] got v=%0b want 0", i, b_valid);
      end
    end
  endtask

  // impulse on ch0 every cycle; caller loads cfg k=4 l=2 m1=1 m2=0
  task automatic test_back_to_back();
    int e[8] = '{100, 200, -100, 0, 0, 0, 0, 0};
    logic signed [15:0] w;
    int j;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, 2'd0, (i == 0) ? 100 : 0);
      else drive(1'b0, 2'd0, 0);
      step();
      j = i - 3;
      total++;
      if (j >= 0) begin
        w = 16'(e[j]);
        if (a_valid !== 1'b1 || a_data !== w || a_chan !== 1'b0) begin
          bad++;
          $display("FAIL b2b[%0d] got v=%0b d=%0d want 1/%0d",
                   i, a_valid, a_data, w);
        end
      end else if (a_valid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle[%0d] got v=%0b want 0", i, a_valid);
      end
    end
    step();
    total++;
    if (a_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_tail got v=%0b want 0", a_valid);
    end
  endtask

  // k=2 l=0 m1=0 m2=1: q must use the freshly updated p
  task automatic test_m2();
    logic signed [15:0] w;
    load(2, 0, 0, 1, 1'b0);
    w = -16'sd100;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b1, 2'd0, (i == 0) ? 100 : 0);
      else drive(1'b0, 2'd0, 0);
      step();
      if (i >= 3) begin
        total++;
        if (a_valid !== 1'b1 || a_data !== w) begin
          bad++;
          $display("FAIL m2[%0d] got v=%0b d=%0d want 1/%0d",
                   i, a_valid, a_data, w);
        end
      end
    end
  endtask

  task automatic test_saturate();
    load(4, 2, 1, 0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, 2'd0, 127);
      else drive(1'b0, 2'd0, 0);
      step();
      total++;
      if (i >= 3) begin
        if (c_valid !== 1'b1 || c_data !== 8'sd127 ||
            c_ovf !== (i >= 4)) begin
          bad++;
          $display("FAIL sat[%0d] got v=%0b d=%0d ovf=%0b want 1/127/%0b",
                   i, c_valid, c_data, c_ovf, (i >= 4));
        end
      end else if (c_valid !== 1'b0 || c_ovf !== 1'b0) begin
        bad++;
        $display("FAIL sat_idle[%0d] got v=%0b ovf=%0b want 0/0",
                 i, c_valid, c_ovf);
      end
    end
    step();
    step();
    total++;
    if (c_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got %0b want 1", c_ovf);
    end
    load(4, 2, 1, 0, 1'b0);
    total++;
    if (c_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_cfg_clear got %0b want 0", c_ovf);
    end
  endtask

  task automatic test_reset_mid();
    load(4, 2, 1, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, (i == 0) ? 100 : 0);
      step();
    end
    drive(1'b0, 2'd0, 0);
    total++;
    if (a_valid !== 1'b1 || a_data !== 16'sd200 || c_ovf !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got v=%0b d=%0d covf=%0b want 1/200/1",
               a_valid, a_data, c_ovf);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (a_valid !== 1'b0 || a_data !== 16'sd0 || a_ovf !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%0b d=%0d ovf=%0b want 0/0/0",
               a_valid, a_data, a_ovf);
    end
    total++;
    if (c_ovf !== 1'b0 || b_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_bc got covf=%0b bv=%0b want 0/0",
               c_ovf, b_valid);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (a_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_reset[%0d] got v=%0b want 0", i, a_valid);
      end
    end
    load(4, 2, 1, 0, 1'b0);
    test_back_to_back();
  endtask

  task automatic test_cfg_flush();
    load(2, 0, 0, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 100);
      step();
    end
    load(4, 2, 1, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush[%0d] got av=%0b bv=%0b want 0/0",
                 i, a_valid, b_valid);
      end
      step();
    end
    test_back_to_back();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_round_robin();
    load(4, 2, 1, 0, 1'b0);
    test_back_to_back();
    test_m2();
    test_saturate();
    test_reset_mid();
    test_cfg_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
